char_draw_sequencer: RTL and testbench
======================================

# char_draw_sequencer

Per-character draw controller for the text-overlay path. Sits directly upstream of `screen_row_counter`:
- Accepts one draw request carrying a character code and screen position.
- Walks the glyph row by row, fetching each row bitmap from the synchronous font ROM.
- Pulses the row counter's `start` for each row, then serialises the row into pixel writes for the framebuffer.
- Uses the row counter's `finish` as the end-of-row cross-check.

## Interface
- `CHAR_WIDTH`, 20: pixels per glyph row. Must equal the downstream row counter's `CHAR_WIDTH`; legal range 2–32.
- `CHAR_HEIGHT`, 20: rows per glyph; legal range 1–32.
- `FONT_ADDR_W`, 13: font ROM address width; must be ≥ ceil(log2(256·CHAR_HEIGHT)).
- `clock` in 1: single clock, all state on rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `draw_req` in 1: request strobe, sampled only when `ready`=1.
- `char_code` in 8: glyph index, latched on accept.
- `x_base` in 10: glyph left column, latched on accept.
- `y_base` in 9: glyph top row, latched on accept.
- `font_data` in CHAR_WIDTH: ROM row bitmap, valid one cycle after `font_addr`; bit CHAR_WIDTH-1 is the leftmost pixel.
- `row_done` in 1: `finish` from `screen_row_counter`.
- `font_addr` out FONT_ADDR_W: equals char_code·CHAR_HEIGHT + row.
- `row_start` out 1: one-cycle pulse to `screen_row_counter.start`.
- `pix_we` out 1: pixel write strobe.
- `pix_on` out 1: pixel foreground bit.
- `pix_x` out 10: write column.
- `pix_y` out 9: write row.
- `ready` out 1: high only in IDLE.
- `done` out 1: one-cycle pulse when the glyph is complete.
- `err` out 1: sticky row-sync error (see Configuration).

## Operation
- States: IDLE, FETCH, LOAD, PIXEL, DONE.
- **IDLE**
  - `ready`=1.
  - On `draw_req`=1: latch `char_code`, `x_base`, `y_base`; clear row and column; go to FETCH.
- **FETCH**
  - Drive `font_addr` for the current row; go to LOAD.
  - `font_addr` is held registered until the next FETCH.
- **LOAD**
  - Latch `font_data` into the row shift register.
  - Assert `row_start` for this cycle only; go to PIXEL with col=0.
- **PIXEL** (CHAR_WIDTH cycles)
  - `pix_we`=1 and `pix_on` = shift-register MSB.
  - `pix_x` = x_base+col, mod 2^10; `pix_y` = y_base+row, mod 2^9; wrap is silent.
  - Shift left and increment col each cycle.
  - After col = CHAR_WIDTH-1: if row = CHAR_HEIGHT-1, go to DONE; otherwise row++ and go to FETCH.
- **DONE**
  - `done`=1 for one cycle; go to IDLE.
- `draw_req` while busy is ignored; no queuing.
- `char_code`/`x_base`/`y_base` changes after accept have no effect.
- Reset, asynchronous at any time including mid-glyph:
  - state IDLE, `ready`=1.
  - `row_start`, `pix_we`, `pix_on`, `done`, `err` = 0.
  - `font_addr`, `pix_x`, `pix_y` = 0; row, col and shift register cleared.
  - The partially drawn glyph is abandoned.

## Timing
- Accept at cycle 0 → FETCH 1, LOAD 2, row-0 pixels at cycles 3..CHAR_WIDTH+2.
- Per-row cost: CHAR_WIDTH+2 cycles.
- `done` fires at cycle 1 + CHAR_HEIGHT·(CHAR_WIDTH+2); 441 for 20×20.
- Earliest next accept is cycle 442 (back in IDLE).
- `row_start` in cycle t puts the row counter in bit k-1 at cycle t+k. `row_done` is therefore expected high exactly in the PIXEL cycle with col = CHAR_WIDTH-1.
- Outputs are registered and change only on clock edges, except under asynchronous reset.

## Configuration
- `CHAR_SEQ_SYNC_CHECK_EN` defined:
  - In each PIXEL cycle, `err` is set if `row_done` ≠ (col == CHAR_WIDTH-1).
  - `err` is sticky and cleared only by reset.
  - Sequencing is unaffected.
- Not defined: `err` is tied 0 and `row_done` is unused.

## Structure
- Package `char_seq_pkg`:
  - State enum (IDLE, FETCH, LOAD, PIXEL, DONE).
  - Default CHAR_WIDTH/CHAR_HEIGHT constants.
  - FONT_ADDR_W constant.
  - Screen coordinate widths (10/9).
- Sub-module `glyph_row_shifter`: CHAR_WIDTH-bit load/shift register with `load`, `shift` and `msb` ports; async active-low reset.
- Address multiply: constant-multiply by CHAR_HEIGHT at accept; increment by 1 per row thereafter.

## Test plan
- **Reset:** hold `resetn`=0 → `ready`=1 and all other outputs 0; release, no request → outputs stay idle.
- **Single glyph:** char_code=8'h41, x_base=100, y_base=50, font_data=20'h80001 on every row.
  - 400 `pix_we` cycles.
  - pix_x 100..119 per row, pix_y 50..69.
  - `pix_on`=1 only at x=100 and x=119.
  - `done` at cycle 441.
  - `font_addr` sequence 1300..1319.
- **Wrap:** x_base=1015, y_base=505 → pix_x wraps from 1023 to 0..10; pix_y wraps from 511 to 0..12; no stall.
- **Busy request:** assert `draw_req` with a new code during row 3 → ignored; no second `done`; `ready` stays 0 until IDLE.
- **Mid-operation reset:** assert `resetn`=0 at cycle 200 → IDLE and outputs 0 immediately; a new request after release restarts at row 0.
- **Sync check** (`CHAR_SEQ_SYNC_CHECK_EN`):
  - With a real `screen_row_counter` attached → `err` stays 0.
  - Force `row_done`=1 at col 5 → `err`=1 next cycle and stays 1 until reset.

Source files
------------

// File: rtl/char_seq_pkg.sv
// Shared types and constants for the character draw sequencer.
package char_seq_pkg;

  localparam int CHAR_WIDTH_DEF  = 20;
  localparam int CHAR_HEIGHT_DEF = 20;
  localparam int FONT_ADDR_W_DEF = 13;
  localparam int X_W             = 10;
  localparam int Y_W             = 9;
  // Row/column counters; covers the full legal 1..32 glyph range.
  localparam int CNT_W           = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_PIXEL = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  typedef struct packed {
    logic [X_W-1:0] x_base;
    logic [Y_W-1:0] y_base;
  } glyph_pos_t;

endpackage

// File: rtl/glyph_row_shifter.sv
// Load/shift register holding one glyph row bitmap; MSB is the current pixel.
module glyph_row_shifter #(
  parameter int W = 20
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load)       sr_d = din;
    else if (shift) sr_d = {sr_q[W-2:0], 1'b0};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) sr_q <= '0;
    else         sr_q <= sr_d;
  end

  assign msb = sr_q[W-1];

endmodule

// File: rtl/char_draw_sequencer.sv
// Per-character draw controller: fetches glyph rows from the font ROM and
// serialises them into pixel writes. Row-sync checking: CHAR_SEQ_SYNC_CHECK_EN.
module char_draw_sequencer
  import char_seq_pkg::*;
#(
  parameter int CHAR_WIDTH  = CHAR_WIDTH_DEF,
  parameter int CHAR_HEIGHT = CHAR_HEIGHT_DEF,
  parameter int FONT_ADDR_W = FONT_ADDR_W_DEF
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   draw_req,
  input  logic [7:0]             char_code,
  input  logic [X_W-1:0]         x_base,
  input  logic [Y_W-1:0]         y_base,
  input  logic [CHAR_WIDTH-1:0]  font_data,
  input  logic                   row_done,
  output logic [FONT_ADDR_W-1:0] font_addr,
  output logic                   row_start,
  output logic                   pix_we,
  output logic                   pix_on,
  output logic [X_W-1:0]         pix_x,
  output logic [Y_W-1:0]         pix_y,
  output logic                   ready,
  output logic                   done,
  output logic                   err
);

  localparam logic [CNT_W-1:0]       LAST_COL = CNT_W'(CHAR_WIDTH - 1);
  localparam logic [CNT_W-1:0]       LAST_ROW = CNT_W'(CHAR_HEIGHT - 1);
  localparam logic [FONT_ADDR_W-1:0] H_MUL    = FONT_ADDR_W'(CHAR_HEIGHT);

  state_e                 state_q, state_d;
  glyph_pos_t             pos_q, pos_d;
  logic [CNT_W-1:0]       row_q, row_d;
  logic [CNT_W-1:0]       col_q, col_d;
  logic [FONT_ADDR_W-1:0] addr_q, addr_d;
  logic [X_W-1:0]         pix_x_q, pix_x_d;
  logic [Y_W-1:0]         pix_y_q, pix_y_d;
  logic                   pix_we_q, pix_we_d;
  logic                   row_start_q, row_start_d;
  logic                   done_q, done_d;
  logic                   ready_q, ready_d;
  logic                   last_col, last_row;
  logic                   row_msb;

  assign last_col = (col_q == LAST_COL);
  assign last_row = (row_q == LAST_ROW);

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    row_d   = row_q;
    col_d   = col_q;
    addr_d  = addr_q;
    pix_x_d = pix_x_q;
    pix_y_d = pix_y_q;
    case (state_q)
      S_IDLE: begin
        if (draw_req) begin
          pos_d   = '{x_base: x_base, y_base: y_base};
          row_d   = '0;
          col_d   = '0;
          addr_d  = FONT_ADDR_W'(char_code) * H_MUL;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        col_d   = '0;
        state_d = S_PIXEL;
      end
      S_PIXEL: begin
        if (last_col) begin
          col_d = '0;
          if (last_row) begin
            state_d = S_DONE;
          end else begin
            // Next row's address lands in the register as FETCH begins.
            row_d   = row_q + CNT_W'(1);
            addr_d  = addr_q + FONT_ADDR_W'(1);
            state_d = S_FETCH;
          end
        end else begin
          col_d = col_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // All strobes are registered copies of the next-state decode.
    pix_we_d    = (state_d == S_PIXEL);
    row_start_d = (state_d == S_LOAD);
    done_d      = (state_d == S_DONE);
    ready_d     = (state_d == S_IDLE);
    if (pix_we_d) begin
      pix_x_d = pos_d.x_base + X_W'(col_d);
      pix_y_d = pos_d.y_base + Y_W'(row_d);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      pos_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      addr_q      <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_we_q    <= 1'b0;
      row_start_q <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      row_q       <= row_d;
      col_q       <= col_d;
      addr_q      <= addr_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_we_q    <= pix_we_d;
      row_start_q <= row_start_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
    end
  end

  glyph_row_shifter #(.W(CHAR_WIDTH)) u_shifter (
    .clock  (clock),
    .resetn (resetn),
    .load   (state_q == S_LOAD),
    .shift  (state_q == S_PIXEL),
    .din    (font_data),
    .msb    (row_msb)
  );

`ifdef CHAR_SEQ_SYNC_CHECK_EN
  logic err_q, err_d;

  // The row counter must finish exactly on the last pixel of each row.
  always_comb begin
    err_d = err_q;
    if (state_q == S_PIXEL && (row_done != last_col)) err_d = 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_row_done;
  assign unused_row_done = row_done;
  assign err = 1'b0;
`endif

  assign font_addr = addr_q;
  assign row_start = row_start_q;
  assign pix_we    = pix_we_q;
  assign pix_on    = pix_we_q & row_msb;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign ready     = ready_q;
  assign done      = done_q;

endmodule

// File: tb/tb_char_draw_sequencer.sv
// Bench for char_draw_sequencer: font ROM and row-counter models, randomized
// glyphs checked cycle by cycle against a timeline model of the draw.
module tb_char_draw_sequencer;

  localparam int W   = 20;
  localparam int H   = 20;
  localparam int AW  = 13;
  localparam int L   = W + 2;
  localparam int N   = H * L;
  localparam int VW  = 6 + 10 + 9 + AW;
  localparam int END = N + 1;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          draw_req = 1'b0;
  logic [7:0]    char_code = '0;
  logic [9:0]    x_base = '0;
  logic [8:0]    y_base = '0;
  logic [W-1:0]  font_data;
  logic          row_done;
  logic [AW-1:0] font_addr;
  logic          row_start, pix_we, pix_on, ready, done, err;
  logic [9:0]    pix_x;
  logic [8:0]    pix_y;

  int errors = 0;
  int checks = 0;
  logic          force_rd = 1'b0;
  logic [W-1:0]  font_mem [0:256*H-1];
  logic [VW-1:0] obs_a [0:511];
  int            rc_cnt;

  char_draw_sequencer #(.CHAR_WIDTH(W), .CHAR_HEIGHT(H), .FONT_ADDR_W(AW)) dut (
    .clock(clock), .resetn(resetn), .draw_req(draw_req), .char_code(char_code),
    .x_base(x_base), .y_base(y_base), .font_data(font_data), .row_done(row_done),
    .font_addr(font_addr), .row_start(row_start), .pix_we(pix_we), .pix_on(pix_on),
    .pix_x(pix_x), .pix_y(pix_y), .ready(ready), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  // Synchronous font ROM: data one cycle after the address.
  always @(posedge clock) font_data <= font_mem[font_addr];

  // Row counter: finish high CHAR_WIDTH cycles after start.
  always @(posedge clock or negedge resetn) begin
    if (!resetn)                        rc_cnt <= 0;
    else if (row_start)                 rc_cnt <= 1;
    else if (rc_cnt != 0 && rc_cnt < W) rc_cnt <= rc_cnt + 1;
    else                                rc_cnt <= 0;
  end
  assign row_done = force_rd | (rc_cnt == W);

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Layout: ready done row_start pix_we pix_on err pix_x pix_y font_addr
  function automatic logic [VW-1:0] pack_obs();
    return {ready, done, row_start, pix_we, pix_on, err, pix_x, pix_y, font_addr};
  endfunction

  // Expected outputs t cycles after accept, from the row/phase timeline.
  function automatic void model_at(input int t, input logic [7:0] code, input logic [9:0] x,
                                   input logic [8:0] y, input int force_t,
                                   output logic [VW-1:0] ev, output logic [VW-1:0] em);
    int r, ph, c, base;
    logic rdy, dn, rs, we, on, e;
    logic [9:0] px;
    logic [8:0] py;
    logic [AW-1:0] ad;
    logic [W-1:0] rowbits;
    base = int'(code) * H;
    rdy = 0; dn = 0; rs = 0; we = 0; on = 0; px = '0; py = '0;
    e = (force_t > 0) && (t > force_t);
    em = '1;
    if (t <= N) begin
      r  = (t - 1) / L;
      ph = (t - 1) % L;
      rs = (ph == 1);
      if (ph >= 2) begin
        c  = ph - 2;
        we = 1;
        rowbits = font_mem[base + r];
        on = rowbits[W-1-c];
        px = 10'((int'(x) + c) % 1024);
        py = 9'((int'(y) + r) % 512);
      end else begin
        em[31:13] = '0;
      end
    end else begin
      r = H - 1;
      em[31:13] = '0;
      if (t == END) dn = 1; else rdy = 1;
    end
    ad = AW'(base + r);
    ev = {rdy, dn, rs, we, on, e, px, py, ad};
  endfunction

  // Waits for ready, issues a request and records ncyc cycles of outputs.
  task automatic play_glyph(input logic [7:0] code, input logic [9:0] x, input logic [8:0] y,
                            input int busy_t, input int force_t, input int ncyc);
    int w = 0;
    while (ready !== 1'b1 && w < 1000) begin @(negedge clock); w++; end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout ready=%b want 1", ready);
    end
    char_code = code; x_base = x; y_base = y; draw_req = 1'b1;
    for (int t = 1; t <= ncyc; t++) begin
      @(negedge clock);
      obs_a[t] = pack_obs();
      force_rd  = (t == force_t);
      draw_req  = (busy_t > 0) && (t >= busy_t) && (t < busy_t + 6);
      char_code = 8'($urandom);
      x_base    = 10'($urandom);
      y_base    = 9'($urandom);
    end
    draw_req = 1'b0;
    force_rd = 1'b0;
  endtask

  task automatic fill_font();
    for (int i = 0; i < 256*H; i++) font_mem[i] = W'($urandom);
  endtask

  task automatic test_reset();
    logic [VW-1:0] idle_v;
    idle_v = {1'b1, {(VW-1){1'b0}}};
    resetn = 1'b0;
    #23;
    checks++;
    if (pack_obs() !== idle_v) begin
      errors++;
      $display("FAIL reset_hold got %h want %h", pack_obs(), idle_v);
    end
    @(negedge clock); resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (pack_obs() !== idle_v) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got %h want %h", i, pack_obs(), idle_v);
      end
    end
  endtask

  task automatic test_single_glyph();
    logic [VW-1:0] ev, em;
    int nwe = 0, dcyc = -1;
    for (int r = 0; r < H; r++) font_mem[8'h41*H + r] = 20'h80001;
    play_glyph(8'h41, 10'd100, 9'd50, 0, 0, END + 1);
    for (int t = 1; t <= END + 1; t++) begin
      model_at(t, 8'h41, 10'd100, 9'd50, 0, ev, em);
      checks++;
      if ((obs_a[t] & em) !== ev) begin
        errors++;
        $display("FAIL single t=%0d got %h want %h", t, obs_a[t] & em, ev);
      end
      if (obs_a[t][VW-4]) nwe++;
      if (obs_a[t][VW-2] && dcyc < 0) dcyc = t;
    end
    checks++;
    if (nwe !== 400) begin errors++; $display("FAIL single_we_count got %0d want 400", nwe); end
    checks++;
    if (dcyc !== 441) begin errors++; $display("FAIL single_done_cycle got %0d want 441", dcyc); end
  endtask

  task automatic test_wrap();
    logic [VW-1:0] ev, em;
    logic [7:0] code;
    code = 8'($urandom);
    play_glyph(code, 10'd1015, 9'd505, 0, 0, END + 1);
    for (int t = 1; t <= END + 1; t++) begin
      model_at(t, code, 10'd1015, 9'd505, 0, ev, em);
      checks++;
      if ((obs_a[t] & em) !== ev) begin
        errors++;
        $display("FAIL wrap t=%0d got %h want %h", t, obs_a[t] & em, ev);
      end
    end
  endtask

  task automatic test_busy_request();
    logic [VW-1:0] ev, em;
    logic [7:0] code;
    code = 8'($urandom);
    play_glyph(code, 10'($urandom), 9'($urandom), 3*L + 5, 0, END + 1);
    for (int t = 1; t <= END + 1; t++) begin
      model_at(t, code, x_base, y_base, 0, ev, em);
      em[31:13] = '0; ev[31:13] = '0;
      checks++;
      if ((obs_a[t] & em) !== ev) begin
        errors++;
        $display("FAIL busy t=%0d got %h want %h", t, obs_a[t] & em, ev);
      end
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      checks++;
      if (done !== 1'b0 || ready !== 1'b1) begin
        errors++;
        $display("FAIL busy_second_done done=%b ready=%b want done=0 ready=1", done, ready);
      end
    end
  endtask

  task automatic test_random_glyphs();
    logic [VW-1:0] ev, em;
    logic [7:0] code;
    logic [9:0] x;
    logic [8:0] y;
    for (int g = 0; g < 3; g++) begin
      code = 8'($urandom); x = 10'($urandom); y = 9'($urandom);
      play_glyph(code, x, y, 0, 0, END + 1);
      for (int t = 1; t <= END + 1; t++) begin
        model_at(t, code, x, y, 0, ev, em);
        checks++;
        if ((obs_a[t] & em) !== ev) begin
          errors++;
          $display("FAIL back_to_back g=%0d t=%0d got %h want %h", g, t, obs_a[t] & em, ev);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [VW-1:0] ev, em, idle_v;
    logic [7:0] code;
    logic [9:0] x;
    logic [8:0] y;
    idle_v = {1'b1, {(VW-1){1'b0}}};
    code = 8'($urandom); x = 10'($urandom); y = 9'($urandom);
    play_glyph(code, x, y, 0, 0, 199);
    for (int t = 1; t <= 199; t++) begin
      model_at(t, code, x, y, 0, ev, em);
      checks++;
      if ((obs_a[t] & em) !== ev) begin
        errors++;
        $display("FAIL midrst_pre t=%0d got %h want %h", t, obs_a[t] & em, ev);
      end
    end
    @(posedge clock); #2 resetn = 1'b0;
    #1;
    checks++;
    if (pack_obs() !== idle_v) begin
      errors++;
      $display("FAIL midrst_async got %h want %h", pack_obs(), idle_v);
    end
    @(negedge clock); resetn = 1'b1;
    @(negedge clock);
    code = 8'($urandom); x = 10'($urandom); y = 9'($urandom);
    play_glyph(code, x, y, 0, 0, END + 1);
    for (int t = 1; t <= END + 1; t++) begin
      model_at(t, code, x, y, 0, ev, em);
      checks++;
      if ((obs_a[t] & em) !== ev) begin
        errors++;
        $display("FAIL midrst_restart t=%0d got %h want %h", t, obs_a[t] & em, ev);
      end
    end
  endtask

`ifdef CHAR_SEQ_SYNC_CHECK_EN
  task automatic test_sync_check();
    logic [VW-1:0] ev, em;
    logic [7:0] code;
    code = 8'($urandom);
    play_glyph(code, 10'd7, 9'd9, 0, 3 + 5, END + 3);
    for (int t = 1; t <= END + 3; t++) begin
      model_at(t, code, 10'd7, 9'd9, 3 + 5, ev, em);
      checks++;
      if ((obs_a[t] & em) !== ev) begin
        errors++;
        $display("FAIL sync_err t=%0d got %h want %h", t, obs_a[t] & em, ev);
      end
    end
    @(negedge clock); resetn = 1'b0;
    @(negedge clock);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL sync_err_reset err=%b want 0", err); end
    resetn = 1'b1;
    @(negedge clock);
  endtask
`endif

  initial begin
    fill_font();
    test_reset();
    test_single_glyph();
    test_wrap();
    test_busy_request();
    test_random_glyphs();
    test_mid_reset();
`ifdef CHAR_SEQ_SYNC_CHECK_EN
    test_sync_check();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
